vram_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM (1-cycle read latency) between the Z80
//  bus and the ULA video fetcher. Video has priority; the CPU is held off with
//  an active-low wait. A streak counter stops video from starving the CPU.

---
 rtl/vram_arbiter_if.sv | 40 ++++
 rtl/vram_arbiter.sv | 132 +++++++++++++
 tb/tb_vram_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the VRAM arbiter and its neighbours: Z80 decode, ULA video fetcher and the RAM.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
interface vram_arbiter_if #(
   parameter int ADDR_W = 15
);
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_wdata;
   logic [7:0]        cpu_rdata;
   logic              cpu_nwait;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [7:0]        vid_rdata;
   logic              vid_ack;

   logic [ADDR_W-1:0] ram_addr;
   logic [7:0]        ram_wdata;
   logic              ram_we;
   logic [7:0]        ram_q;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_nwait,
      input  vid_req, vid_addr,
      output vid_rdata, vid_ack,
      output ram_addr, ram_wdata, ram_we,
      input  ram_q
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_nwait,
      output vid_req, vid_addr,
      input  vid_rdata, vid_ack,
      input  ram_addr, ram_wdata, ram_we,
      output ram_q
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the Z80 and the ULA video fetcher.
// Video normally has priority. A streak counter forces one CPU grant after MAX_VID_BURST video grants.
module vram_arbiter #(
   parameter int ADDR_W        = 15,
   parameter int MAX_VID_BURST = 4
) (
   input logic           clk_vram,
   input logic           nreset,
   vram_arbiter_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      VRD,
      VCAP,
      CRD,
      CCAP,
      CWR
   } state_t;

   localparam int                  STREAK_W   = $clog2(MAX_VID_BURST + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_VID_BURST);

   state_t              state, state_d;
   logic [STREAK_W-1:0] vid_streak, vid_streak_d;
   logic                cpu_done;
   logic                cpu_active;
   logic                cpu_pend;
   logic                streak_cap;
   logic                grant_vid, grant_cpu;
   logic                cap_vid, cap_cpu, cwr_end;

   assign cpu_active = (state == CRD) || (state == CCAP) || (state == CWR);
   assign cpu_pend   = bus.cpu_req & ~cpu_done & ~cpu_active;
   assign streak_cap = cpu_pend & (vid_streak == STREAK_MAX);

   // The wait is held released during reset.
   // Otherwise a CPU cycle that was in flight would stall the Z80 until reset is removed.
   assign bus.cpu_nwait = ~nreset | ~(bus.cpu_req & ~cpu_done);

   // NOTE: every signal gets a default before the case; a path that skips an assignment would infer a latch.
   always_comb begin
      state_d      = state;
      vid_streak_d = vid_streak;
      grant_vid    = 1'b0;
      grant_cpu    = 1'b0;
      cap_vid      = 1'b0;
      cap_cpu      = 1'b0;
      cwr_end      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.vid_req && !streak_cap) begin
               grant_vid = 1'b1;
               state_d   = VRD;
               if (!cpu_pend)
                  vid_streak_d = '0;
               else if (vid_streak != STREAK_MAX)
                  vid_streak_d = vid_streak + STREAK_W'(1);
            end else if (cpu_pend) begin
               grant_cpu    = 1'b1;
               state_d      = bus.cpu_we ? CWR : CRD;
               vid_streak_d = '0;
            end
         end
         VRD:  state_d = VCAP;
         VCAP: begin
            cap_vid = 1'b1;
            state_d = IDLE;
         end
         CRD:  state_d = CCAP;
         CCAP: begin
            cap_cpu = 1'b1;
            state_d = IDLE;
         end
         CWR: begin
            cwr_end = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_vram or negedge nreset) begin
      if (!nreset) state <= IDLE;
      else         state <= state_d;
   end

   // NOTE: clocked state uses non-blocking assignments, so every register samples values from before the edge.
   always_ff @(posedge clk_vram or negedge nreset) begin
      if (!nreset) begin
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
         bus.ram_we    <= 1'b0;
         bus.cpu_rdata <= 8'hFF;
         bus.vid_rdata <= '0;
         bus.vid_ack   <= 1'b0;
         cpu_done      <= 1'b0;
         vid_streak    <= '0;
      end else begin
         bus.vid_ack <= cap_vid;
         vid_streak  <= vid_streak_d;

         if (grant_vid)
            bus.ram_addr <= bus.vid_addr;
         if (grant_cpu) begin
            bus.ram_addr  <= bus.cpu_addr;
            bus.ram_wdata <= bus.cpu_wdata;
            bus.ram_we    <= bus.cpu_we;
         end
         if (cwr_end)
            bus.ram_we <= 1'b0;

         if (cap_vid)
            bus.vid_rdata <= bus.ram_q;
         if (cap_cpu)
            bus.cpu_rdata <= bus.ram_q;

         // Completion only counts if the CPU is still asking; a dropped request just lets the access finish.
         if (!bus.cpu_req)
            cpu_done <= 1'b0;
         else if (cap_cpu || cwr_end)
            cpu_done <= 1'b1;
      end
   end

   a_vid_ack_pulse : assert property (@(posedge clk_vram) disable iff (!nreset)
      bus.vid_ack |=> !bus.vid_ack);

   a_we_only_in_cwr : assert property (@(posedge clk_vram) disable iff (!nreset)
      bus.ram_we |-> (state == CWR));

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
// Cells that were never written read back addr[7:0] ^ 8'h5A.
module tb_vram_arbiter;

   localparam int ADDR_W        = 15;
   localparam int MAX_VID_BURST = 4;

   logic clk_vram = 1'b0;
   logic nreset   = 1'b0;

   always #5 clk_vram = ~clk_vram;

   vram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   vram_arbiter #(
      .ADDR_W        (ADDR_W),
      .MAX_VID_BURST (MAX_VID_BURST)
   ) dut (
      .clk_vram (clk_vram),
      .nreset   (nreset),
      .bus      (bus)
   );

   logic [7:0] mem     [0:(1<<ADDR_W)-1];
   bit         written [0:(1<<ADDR_W)-1];
   logic [7:0] ram_q_r = 8'h00;

   function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   always @(posedge clk_vram) begin
      if (bus.ram_we) begin
         mem[bus.ram_addr]     <= bus.ram_wdata;
         written[bus.ram_addr] <= 1'b1;
      end
      ram_q_r <= written[bus.ram_addr] ? mem[bus.ram_addr] : pat(bus.ram_addr);
   end
   assign bus.ram_q = ram_q_r;

   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) checks_passed++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk_vram);
      #1;
   endtask

   task automatic cpu_read_check(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string tag);
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = a;
      #1;
      check({tag, "_wait_n0"}, 32'(bus.cpu_nwait), 32'd0);
      for (int i = 1; i <= 2; i++) begin
         tick();
         check({tag, "_wait_n"}, 32'(bus.cpu_nwait), 32'd0);
      end
      tick();
      check({tag, "_release"}, 32'(bus.cpu_nwait), 32'd1);
      check({tag, "_data"}, 32'(bus.cpu_rdata), 32'(exp));
      bus.cpu_req = 1'b0;
      repeat (2) tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [ADDR_W-1:0] vaddr  [5];
   logic [7:0]        vexp   [5];
   int                ack_at [5];
   int                acks;
   int                we_cnt;
   int                nwait_hi;
   bit                served;

   initial begin
      vaddr  = '{15'h40FF, 15'h4080, 15'h4033, 15'h4055, 15'h4010};
      vexp   = '{8'hA5, 8'hDA, 8'h69, 8'h0F, 8'h4A};
      ack_at = '{3, 6, 9, 12, 18};

      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;

      // Reset with cpu_req high
      repeat (2) tick();
      check("rst_nwait", 32'(bus.cpu_nwait), 32'd1);
      check("rst_ram_we", 32'(bus.ram_we), 32'd0);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'hFF);
      check("rst_vid_ack", 32'(bus.vid_ack), 32'd0);
      check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      check("rst_vid_rdata", 32'(bus.vid_rdata), 32'd0);
      bus.cpu_req = 1'b0;
      nreset      = 1'b1;
      repeat (2) tick();

      // CPU write 0x1234 <- 0xA5
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 15'h1234;
      bus.cpu_wdata = 8'hA5;
      #1;
      check("wr_n_nwait", 32'(bus.cpu_nwait), 32'd0);
      check("wr_n_we", 32'(bus.ram_we), 32'd0);
      tick();
      check("wr_n1_we", 32'(bus.ram_we), 32'd1);
      check("wr_n1_addr", 32'(bus.ram_addr), 32'h1234);
      check("wr_n1_wdata", 32'(bus.ram_wdata), 32'hA5);
      check("wr_n1_nwait", 32'(bus.cpu_nwait), 32'd0);
      tick();
      check("wr_n2_we", 32'(bus.ram_we), 32'd0);
      check("wr_n2_nwait", 32'(bus.cpu_nwait), 32'd1);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      repeat (2) tick();

      cpu_read_check(15'h1234, 8'hA5, "rd_1234");

      // CPU write abandoned after the grant still lands
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 15'h0200;
      bus.cpu_wdata = 8'h81;
      tick();
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      #1;
      check("drop_we", 32'(bus.ram_we), 32'd1);
      check("drop_nwait", 32'(bus.cpu_nwait), 32'd1);
      tick();
      check("drop_we_off", 32'(bus.ram_we), 32'd0);
      repeat (2) tick();
      cpu_read_check(15'h0200, 8'h81, "rd_0200");

      // Simultaneous requests with streak 0: video first
      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'h4010;
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 15'h2222;
      tick();
      check("sim_n1_addr", 32'(bus.ram_addr), 32'h4010);
      check("sim_n1_ack", 32'(bus.vid_ack), 32'd0);
      tick();
      check("sim_n2_ack", 32'(bus.vid_ack), 32'd0);
      tick();
      check("sim_n3_ack", 32'(bus.vid_ack), 32'd1);
      check("sim_n3_vdata", 32'(bus.vid_rdata), 32'h4A);
      check("sim_n3_nwait", 32'(bus.cpu_nwait), 32'd0);
      bus.vid_req = 1'b0;
      tick();
      check("sim_n4_ack", 32'(bus.vid_ack), 32'd0);
      tick();
      check("sim_n5_nwait", 32'(bus.cpu_nwait), 32'd0);
      tick();
      check("sim_n6_nwait", 32'(bus.cpu_nwait), 32'd1);
      check("sim_n6_cdata", 32'(bus.cpu_rdata), 32'h78);
      bus.cpu_req = 1'b0;
      repeat (2) tick();

      // Held video request against a pending CPU read: 4 video, CPU, then video
      acks         = 0;
      served       = 1'b0;
      bus.vid_req  = 1'b1;
      bus.vid_addr = vaddr[0];
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 15'h1234;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         tick();
         if (bus.vid_ack) begin
            if (acks < 5) begin
               check("streak_ack_cycle", 32'(cyc), 32'(ack_at[acks]));
               check("streak_ack_data", 32'(bus.vid_rdata), 32'(vexp[acks]));
            end
            acks++;
            if (acks < 5) bus.vid_addr = vaddr[acks];
            else          bus.vid_req  = 1'b0;
         end
         if (bus.cpu_req && bus.cpu_nwait) begin
            check("streak_cpu_cycle", 32'(cyc), 32'd15);
            check("streak_acks_before_cpu", 32'(acks), 32'd4);
            check("streak_cpu_data", 32'(bus.cpu_rdata), 32'hA5);
            served      = 1'b1;
            bus.cpu_req = 1'b0;
         end
      end
      check("streak_ack_count", 32'(acks), 32'd5);
      check("streak_cpu_served", 32'(served), 32'd1);
      bus.vid_req = 1'b0;
      bus.cpu_req = 1'b0;
      repeat (2) tick();

      // cpu_req held 20 cycles: one write only
      we_cnt        = 0;
      nwait_hi      = 0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 15'h0100;
      bus.cpu_wdata = 8'h3C;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         tick();
         we_cnt   += int'(bus.ram_we);
         nwait_hi += int'(bus.cpu_nwait);
      end
      check("held_we_count", 32'(we_cnt), 32'd1);
      check("held_nwait_high", 32'(nwait_hi), 32'd19);
      bus.cpu_req = 1'b0;
      bus.cpu_we  = 1'b0;
      repeat (2) tick();
      cpu_read_check(15'h0100, 8'h3C, "rd_0100");

      // Reset asserted while a video fetch sits in VRD
      bus.vid_req  = 1'b1;
      bus.vid_addr = 15'h4055;
      tick();
      check("vrd_addr", 32'(bus.ram_addr), 32'h4055);
      bus.cpu_req = 1'b1;
      nreset      = 1'b0;
      #1;
      check("mid_rst_nwait", 32'(bus.cpu_nwait), 32'd1);
      check("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
      check("mid_rst_vdata", 32'(bus.vid_rdata), 32'd0);
      bus.vid_req = 1'b0;
      bus.cpu_req = 1'b0;
      repeat (2) tick();
      nreset = 1'b1;
      acks   = 0;
      for (int cyc = 1; cyc <= 6; cyc++) begin
         tick();
         acks += int'(bus.vid_ack);
      end
      check("mid_rst_no_ack", 32'(acks), 32'd0);
      check("mid_rst_cdata", 32'(bus.cpu_rdata), 32'hFF);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
